// File: rtl/regfile_sb.sv
// Register file with NRP combinational read ports, one write-back port and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-back-to-read forwarding.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 3,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    output logic [AW:0]         busy_cnt,
    output logic                sb_full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(NREGS - 1);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             wb_en;
    logic             iss_en;
    logic             cnt_inc;
    logic             cnt_dec;

    // x0 is hardwired: its stored value stays 0 and it is never marked busy.
    assign wb_en  = wb_valid  && (wb_addr  != '0);
    assign iss_en = iss_valid && (iss_addr != '0);

    // A count change only happens on a real bit transition, so the counter
    // tracks the population of busy bits exactly and cannot wrap.
    assign cnt_inc = iss_en && !busy[iss_addr];
    assign cnt_dec = wb_en && busy[wb_addr] && !(iss_en && (iss_addr == wb_addr));

    always_comb begin
        busy_next = busy;
        // NOTE: blocking assignments in order, so an issue to the same address overrides the write-back clear.
        if (wb_en)  busy_next[wb_addr]  = 1'b0;
        if (iss_en) busy_next[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
            busy     <= busy_next;
            busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    // NOTE: the storage array is reset too, because reads must return 0 immediately after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign sb_full = (busy_cnt == FULL_CNT);

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            rd_data[k*XLEN +: XLEN] = regs[ra];
            rd_busy[k]              = busy[ra];
`ifdef REGFILE_BYPASS_EN
            // Forwarded value is fresh unless the same edge re-issues the register.
            if (wb_en && (ra == wb_addr)) begin
                rd_data[k*XLEN +: XLEN] = wb_data;
                rd_busy[k]              = iss_en && (iss_addr == wb_addr);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table plus reset, bypass and full-scoreboard sequences.
// Runs the default 32x32/3-port instance and a 16-register/4-port instance.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [14:0] rd_addr = '0;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [5:0]  busy_cnt;
    logic        sb_full;

    logic [15:0]  rd_addr_b = '0;
    logic [127:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic         wb_valid_b = 1'b0;
    logic [3:0]   wb_addr_b = '0;
    logic [31:0]  wb_data_b = '0;
    logic         iss_valid_b = 1'b0;
    logic [3:0]   iss_addr_b = '0;
    logic [4:0]   busy_cnt_b;
    logic         sb_full_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .busy_cnt(busy_cnt), .sb_full(sb_full)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .NRP(4)) dut_b (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wb_valid(wb_valid_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
        .iss_valid(iss_valid_b), .iss_addr(iss_addr_b),
        .busy_cnt(busy_cnt_b), .sb_full(sb_full_b)
    );

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_port(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic clear_strobes();
        wb_valid    = 1'b0;
        iss_valid   = 1'b0;
        wb_valid_b  = 1'b0;
        iss_valid_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        //             wv    wa  wd            iv    ia  ra  data          busy  cnt
        vecs[0]  = '{1'b1,  0, 32'hDEADBEEF, 1'b1,  0,  0, 32'h00000000, 1'b0, 6'd0};
        vecs[1]  = '{1'b0,  0, 32'h00000000, 1'b1,  5,  5, 32'h00000000, 1'b1, 6'd1};
        vecs[2]  = '{1'b0,  0, 32'h00000000, 1'b1,  6,  6, 32'h00000000, 1'b1, 6'd2};
        vecs[3]  = '{1'b1,  5, 32'h12345678, 1'b0,  0,  5, 32'h12345678, 1'b0, 6'd1};
        vecs[4]  = '{1'b0,  0, 32'h00000000, 1'b1,  7,  7, 32'h00000000, 1'b1, 6'd2};
        vecs[5]  = '{1'b1,  7, 32'hA5A5A5A5, 1'b1,  7,  7, 32'hA5A5A5A5, 1'b1, 6'd2};
        vecs[6]  = '{1'b0,  0, 32'h00000000, 1'b1,  7,  7, 32'hA5A5A5A5, 1'b1, 6'd2};
        vecs[7]  = '{1'b1,  9, 32'h11112222, 1'b0,  0,  9, 32'h11112222, 1'b0, 6'd2};
        vecs[8]  = '{1'b1,  6, 32'hCAFEF00D, 1'b1,  8,  6, 32'hCAFEF00D, 1'b0, 6'd2};
        vecs[9]  = '{1'b0,  0, 32'h00000000, 1'b0,  0,  8, 32'h00000000, 1'b1, 6'd2};
        vecs[10] = '{1'b1,  8, 32'h00000001, 1'b1,  0,  8, 32'h00000001, 1'b0, 6'd1};
        vecs[11] = '{1'b1,  7, 32'hBEEF0000, 1'b0,  0,  7, 32'hBEEF0000, 1'b0, 6'd0};

        // Reset held for two cycles, then released.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        set_port(0, 5'd0); set_port(1, 5'd5); set_port(2, 5'd31);
        #1;
        check("reset_rd_data", {32'h0, rd_data[31:0] | rd_data[63:32] | rd_data[95:64]}, 64'h0);
        check("reset_rd_busy", {61'h0, rd_busy}, 64'h0);
        check("reset_busy_cnt", {58'h0, busy_cnt}, 64'h0);
        check("reset_sb_full", {63'h0, sb_full}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wb_valid = vecs[i].wv; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            iss_valid = vecs[i].iv; iss_addr = vecs[i].ia;
            @(posedge clk);
            #1;
            clear_strobes();
            set_port(0, vecs[i].ra);
            #1;
            check($sformatf("vec%0d_data", i), {32'h0, rd_data[31:0]}, {32'h0, vecs[i].exp_data});
            check($sformatf("vec%0d_busy", i), {63'h0, rd_busy[0]}, {63'h0, vecs[i].exp_busy});
            check($sformatf("vec%0d_cnt", i), {58'h0, busy_cnt}, {58'h0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_full", i), {63'h0, sb_full}, 64'h0);
        end

        // Aliased ports all see x9.
        set_port(0, 5'd9); set_port(1, 5'd9); set_port(2, 5'd9);
        #1;
        check("alias_p1", {32'h0, rd_data[63:32]}, 64'h11112222);
        check("alias_p2", {32'h0, rd_data[95:64]}, 64'h11112222);

        // Reset asserted mid-cycle with a busy register and stored data.
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd10;
        @(posedge clk);
        #1;
        clear_strobes();
        set_port(1, 5'd10);
        #1;
        check("pre_reset_busy", {63'h0, rd_busy[1]}, 64'h1);
        check("pre_reset_cnt", {58'h0, busy_cnt}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_data", {32'h0, rd_data[31:0]}, 64'h0);
        check("async_reset_busy", {63'h0, rd_busy[1]}, 64'h0);
        check("async_reset_cnt", {58'h0, busy_cnt}, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Forwarding: x3 holds 0x11, then written 0x42 while read on port 1.
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        @(posedge clk);
        #1;
        clear_strobes();
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd4;
        @(posedge clk);
        #1;
        clear_strobes();
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h42;
        iss_valid = 1'b1; iss_addr = 5'd3;
        set_port(1, 5'd3);
        #1;
        check("byp_same_cycle_data", {32'h0, rd_data[63:32]}, BYP ? 64'h42 : 64'h11);
        check("byp_same_cycle_busy_issue", {63'h0, rd_busy[1]}, BYP ? 64'h1 : 64'h0);
        @(posedge clk);
        #1;
        clear_strobes();
        #1;
        check("byp_next_cycle_data", {32'h0, rd_data[63:32]}, 64'h42);
        check("byp_next_cycle_busy", {63'h0, rd_busy[1]}, 64'h1);
        check("byp_next_cycle_cnt", {58'h0, busy_cnt}, 64'd2);
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h99;
        set_port(2, 5'd4);
        #1;
        check("byp_clear_data", {32'h0, rd_data[95:64]}, BYP ? 64'h99 : 64'h0);
        check("byp_clear_busy", {63'h0, rd_busy[2]}, BYP ? 64'h0 : 64'h1);
        @(posedge clk);
        #1;
        clear_strobes();
        #1;
        check("wb_x4_data", {32'h0, rd_data[95:64]}, 64'h99);
        check("wb_x4_busy", {63'h0, rd_busy[2]}, 64'h0);
        check("wb_x4_cnt", {58'h0, busy_cnt}, 64'd1);

        // Fill the scoreboard on both instances.
        do_reset();
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            iss_valid = 1'b1; iss_addr = 5'(r);
            if (r < 16) begin
                iss_valid_b = 1'b1; iss_addr_b = 4'(r);
            end else begin
                iss_valid_b = 1'b0;
            end
            @(posedge clk);
            #1;
            clear_strobes();
            if (r == 30) begin
                #1;
                check("fill30_cnt", {58'h0, busy_cnt}, 64'd30);
                check("fill30_full", {63'h0, sb_full}, 64'h0);
            end
            if (r == 14) begin
                #1;
                check("b_fill14_full", {63'h0, sb_full_b}, 64'h0);
            end
        end
        #1;
        check("full_cnt", {58'h0, busy_cnt}, 64'd31);
        check("full_flag", {63'h0, sb_full}, 64'h1);
        check("b_full_cnt", {59'h0, busy_cnt_b}, 64'd15);
        check("b_full_flag", {63'h0, sb_full_b}, 64'h1);

        // Re-issue of a busy register and issue to x0 leave the count saturated.
        @(negedge clk);
        iss_valid = 1'b1; iss_addr = 5'd5;
        iss_valid_b = 1'b1; iss_addr_b = 4'd0;
        @(posedge clk);
        #1;
        clear_strobes();
        #1;
        check("full_reissue_cnt", {58'h0, busy_cnt}, 64'd31);
        check("b_full_x0_cnt", {59'h0, busy_cnt_b}, 64'd15);

        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd31; wb_data = 32'h31;
        wb_valid_b = 1'b1; wb_addr_b = 4'd15; wb_data_b = 32'h77;
        rd_addr_b[12 +: 4] = 4'd15;
        @(posedge clk);
        #1;
        clear_strobes();
        set_port(0, 5'd31);
        #1;
        check("drain_cnt", {58'h0, busy_cnt}, 64'd30);
        check("drain_full", {63'h0, sb_full}, 64'h0);
        check("drain_data", {32'h0, rd_data[31:0]}, 64'h31);
        check("b_drain_cnt", {59'h0, busy_cnt_b}, 64'd14);
        check("b_drain_full", {63'h0, sb_full_b}, 64'h0);
        check("b_p3_data", {32'h0, rd_data_b[127:96]}, 64'h77);
        check("b_p3_busy", {63'h0, rd_busy_b[3]}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
